// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for pipelined_adder: op select, chunk width, saturation limits.
package pipelined_adder_pkg;

    typedef enum logic {
        ADD_OP = 1'b0,
        SUB_OP = 1'b1
    } op_e;

    function automatic int unsigned chunk_width(int unsigned width, int unsigned stages);
        return width / stages;
    endfunction

    // Limits are built 64 bits wide; callers truncate to WIDTH (WIDTH <= 64).
    function automatic logic [63:0] sat_max(int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_c;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_overflow;

    modport master (
        output i_valid, i_a, i_b, i_c, i_sub, i_ready,
        input  o_ready, o_valid, o_sum, o_carry, o_overflow
    );

    modport slave (
        input  i_valid, i_a, i_b, i_c, i_sub, i_ready,
        output o_ready, o_valid, o_sum, o_carry, o_overflow
    );
endinterface

// File: rtl/pipelined_adder_stage.sv
// full_adder cell and adder_stage: one CHUNK-bit registered add slice with
// valid/ready and pass-through operand/partial-sum payload.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);
    localparam int unsigned LSB = IDX * CHUNK;

    logic [CHUNK:0]   chain;
    logic [CHUNK-1:0] chunk_sum;
    logic [WIDTH-1:0] sum_next;

    assign chain[0] = in_carry;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a  (in_a[LSB + i]),
            .b  (in_b[LSB + i]),
            .ci (chain[i]),
            .s  (chunk_sum[i]),
            .co (chain[i + 1])
        );
    end

    always_comb begin
        sum_next = in_sum;
        sum_next[LSB +: CHUNK] = chunk_sum;
    end

    assign in_ready = !out_valid || out_ready;

    // Payload only updates on a real beat so the result holds after draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_a     <= in_a;
                out_b     <= in_b;
                out_sum   <= sum_next;
                out_carry <= chain[CHUNK];
            end
        end
    end
endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep carry-registered WIDTH-bit add/subtract with valid/ready backpressure.
// Optional clamp on signed overflow: define PIPELINED_ADDER_SATURATE_EN.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input logic              i_clk,
    input logic              i_rst,
    pipelined_adder_if.slave bus
);
    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
    localparam int unsigned MSB   = WIDTH - 1;

    logic             valid_p [0:STAGES];
    logic             ready_p [0:STAGES];
    logic [WIDTH-1:0] a_p     [0:STAGES];
    logic [WIDTH-1:0] b_p     [0:STAGES];
    logic [WIDTH-1:0] sum_p   [0:STAGES];
    logic             carry_p [0:STAGES];

    logic             sub;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             unused_low;

    // B is inverted and the carry-in chosen once, at entry.
    assign sub          = (op_e'(bus.i_sub) == SUB_OP);
    assign valid_p[0]   = bus.i_valid;
    assign a_p[0]       = bus.i_a;
    assign b_p[0]       = sub ? ~bus.i_b : bus.i_b;
    assign carry_p[0]   = sub ? 1'b1 : bus.i_c;
    assign sum_p[0]     = '0;
    assign bus.o_ready  = ready_p[0];
    assign ready_p[STAGES] = bus.i_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk       (i_clk),
            .rst       (i_rst),
            .in_valid  (valid_p[k]),
            .in_ready  (ready_p[k]),
            .in_a      (a_p[k]),
            .in_b      (b_p[k]),
            .in_sum    (sum_p[k]),
            .in_carry  (carry_p[k]),
            .out_valid (valid_p[k + 1]),
            .out_ready (ready_p[k + 1]),
            .out_a     (a_p[k + 1]),
            .out_b     (b_p[k + 1]),
            .out_sum   (sum_p[k + 1]),
            .out_carry (carry_p[k + 1])
        );
    end

    assign result   = sum_p[STAGES];
    assign overflow = (a_p[STAGES][MSB] == b_p[STAGES][MSB]) &&
                      (result[MSB] != a_p[STAGES][MSB]);
    assign unused_low = ^{a_p[STAGES], b_p[STAGES]};

    assign bus.o_valid    = valid_p[STAGES];
    assign bus.o_carry    = carry_p[STAGES];
    assign bus.o_overflow = overflow;

`ifdef PIPELINED_ADDER_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    // Operand sign picks the clamp direction: positive operands overflow high.
    assign bus.o_sum = !overflow ? result : (a_p[STAGES][MSB] ? SAT_MIN : SAT_MAX);
`else
    assign bus.o_sum = result;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=8, STAGES=2).
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;
`ifdef PIPELINED_ADDER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       sub;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic sub);
        bus.i_valid = v;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_c     = c;
        bus.i_sub   = sub;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_ready = 1'b1;
        set_beat(1'b1, 8'h11, 8'h22, 1'b0, ADD_OP);
        tick();
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: o_valid=%b expected 0", bus.o_valid);
        end
        n_checks++;
        if (bus.o_sum !== 8'h00) begin
            n_fail++; $display("FAIL reset_sum: o_sum=%h expected 00", bus.o_sum);
        end
        n_checks++;
        if (bus.o_carry !== 1'b0 || bus.o_overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: carry=%b ovf=%b expected 0 0", bus.o_carry, bus.o_overflow);
        end
        rst = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: o_ready=%b expected 1", bus.o_ready);
        end
    endtask

    task automatic test_add_sub();
        vec_t v [5];
        v[0] = {8'hFF, 8'h01, 1'b0, ADD_OP, 8'h00, 1'b1, 1'b0};
        v[1] = {8'h7F, 8'h01, 1'b0, ADD_OP, (SAT ? 8'h7F : 8'h80), 1'b0, 1'b1};
        v[2] = {8'h12, 8'h34, 1'b1, ADD_OP, 8'h47, 1'b0, 1'b0};
        v[3] = {8'h05, 8'h07, 1'b1, SUB_OP, 8'hFE, 1'b0, 1'b0};
        v[4] = {8'h80, 8'h01, 1'b0, SUB_OP, (SAT ? 8'h80 : 8'h7F), 1'b1, 1'b1};
        tick();
        for (int i = 0; i < 5; i++) begin
            set_beat(1'b1, v[i].a, v[i].b, v[i].c, v[i].sub);
            #1;
            n_checks++;
            if (bus.o_ready !== 1'b1) begin
                n_fail++; $display("FAIL addsub_ready[%0d]: o_ready=%b expected 1", i, bus.o_ready);
            end
            tick();
            bus.i_valid = 1'b0;
            #1;
            n_checks++;
            if (bus.o_valid !== 1'b0) begin
                n_fail++; $display("FAIL addsub_latency[%0d]: o_valid=%b expected 0 after 1 cycle", i, bus.o_valid);
            end
            tick();
            n_checks++;
            if (bus.o_valid !== 1'b1 || bus.o_sum !== v[i].sum) begin
                n_fail++; $display("FAIL addsub_sum[%0d]: valid=%b sum=%h expected 1 %h", i, bus.o_valid, bus.o_sum, v[i].sum);
            end
            n_checks++;
            if (bus.o_carry !== v[i].carry || bus.o_overflow !== v[i].ovf) begin
                n_fail++; $display("FAIL addsub_flags[%0d]: carry=%b ovf=%b expected %b %b", i, bus.o_carry, bus.o_overflow, v[i].carry, v[i].ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_sum [3];
        exp_sum[0] = 8'h11; exp_sum[1] = 8'h22; exp_sum[2] = 8'h33;
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) set_beat(1'b1, 8'(16 * (c + 1)), 8'(c + 1), 1'b0, ADD_OP);
            else       bus.i_valid = 1'b0;
            #1;
            n_checks++;
            if (bus.o_valid !== (c >= 2 && c <= 4)) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: o_valid=%b", c, bus.o_valid);
            end else if (c >= 2 && c <= 4) begin
                n_checks++;
                if (bus.o_sum !== exp_sum[c - 2]) begin
                    n_fail++; $display("FAIL b2b_sum[%0d]: o_sum=%h expected %h", c, bus.o_sum, exp_sum[c - 2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic       exp_ready [10];
        logic       exp_valid [10];
        logic [7:0] exp_sum   [10];
        logic [7:0] beat;
        exp_ready = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        exp_valid = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        exp_sum   = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04, 8'h06, 8'h08, 8'h00};
        tick();
        for (int c = 0; c < 10; c++) begin
            bus.i_ready = (c >= 5);
            beat = (c == 0) ? 8'd1 : (c == 1) ? 8'd2 : (c <= 5) ? 8'd3 : (c == 6) ? 8'd4 : 8'd0;
            set_beat(beat != 8'd0, beat, beat, 1'b0, ADD_OP);
            #1;
            n_checks++;
            if (bus.o_ready !== exp_ready[c]) begin
                n_fail++; $display("FAIL bp_ready[%0d]: o_ready=%b expected %b", c, bus.o_ready, exp_ready[c]);
            end
            n_checks++;
            if (bus.o_valid !== exp_valid[c]) begin
                n_fail++; $display("FAIL bp_valid[%0d]: o_valid=%b expected %b", c, bus.o_valid, exp_valid[c]);
            end else if (exp_valid[c]) begin
                n_checks++;
                if (bus.o_sum !== exp_sum[c]) begin
                    n_fail++; $display("FAIL bp_sum[%0d]: o_sum=%h expected %h", c, bus.o_sum, exp_sum[c]);
                end
            end
            tick();
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        tick();
        bus.i_ready = 1'b1;
        set_beat(1'b1, 8'h01, 8'h02, 1'b0, ADD_OP);
        tick();
        set_beat(1'b1, 8'h03, 8'h04, 1'b0, ADD_OP);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_sum !== 8'h00) begin
            n_fail++; $display("FAIL midrst_clear: valid=%b sum=%h expected 0 00", bus.o_valid, bus.o_sum);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (bus.o_valid !== 1'b0) begin
                n_fail++; $display("FAIL midrst_idle[%0d]: o_valid=%b expected 0", c, bus.o_valid);
            end
        end
        set_beat(1'b1, 8'h10, 8'h20, 1'b0, ADD_OP);
        tick();
        bus.i_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_latency: o_valid=%b expected 0", bus.o_valid);
        end
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_sum !== 8'h30 || bus.o_carry !== 1'b0 || bus.o_overflow !== 1'b0) begin
            n_fail++; $display("FAIL midrst_result: valid=%b sum=%h carry=%b ovf=%b expected 1 30 0 0",
                               bus.o_valid, bus.o_sum, bus.o_carry, bus.o_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
